// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the controller state encoding and the register-tag match rule.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    // A source only conflicts with a producer when it is actually read and the
    // producer writes a real register ($zero is never a hazard).
    function automatic logic reg_hit(input logic src_used,
                                     input logic same_reg,
                                     input logic dst_nonzero);
        return src_used & same_reg & dst_nonzero;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy counter: loads the latency on issue, counts down
// on unfrozen cycles and reports busy while non-zero.
module md_busy_counter #(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic hold,
    output logic busy
);

    localparam int MW = $clog2(MD_LAT + 1);

    logic [MW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= MW'(MD_LAT);
        end else if (!hold && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: load-use, branch
// operand, mult/div busy, memory wait and HALT drain handling.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16,
    parameter int DRAIN  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              useRsD,
    input  logic              useRtD,
    input  logic              branchD,
    input  logic [REG_AW-1:0] rwE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic [REG_AW-1:0] rwM,
    input  logic              MemtoRegM,
    input  logic              mdStartD,
    input  logic              mdUseD,
    input  logic              StopD,
    input  logic              memReadyM,
    output logic              stallF,
    output logic              stallD,
    output logic              isLWHazard,
    output logic              freeze,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

    state_t        state, next_state;
    logic [DW-1:0] drain_cnt;
    logic          drain_load, drain_dec;
    logic          md_busy, md_issue;
    logic          match_e, match_m;
    logic          lw_haz, br_haz, md_haz, any_haz;

    assign match_e = reg_hit(useRsD, rsD == rwE, rwE != '0)
                   | reg_hit(useRtD, rtD == rwE, rwE != '0);
    assign match_m = reg_hit(useRsD, rsD == rwM, rwM != '0)
                   | reg_hit(useRtD, rtD == rwM, rwM != '0);

    assign lw_haz  = RegWriteE & MemtoRegE & match_e;
    assign br_haz  = branchD & ((RegWriteE & match_e) | (MemtoRegM & match_m));
    assign md_haz  = md_busy & (mdUseD | mdStartD);
    assign any_haz = lw_haz | br_haz | md_haz;

    // A mult/div only really issues when ID advances into EX this cycle.
    assign md_issue = mdStartD & ~stallD & ~freeze;

    md_busy_counter #(.MD_LAT(MD_LAT)) u_md (
        .clk   (clk),
        .reset (reset),
        .load  (md_issue),
        .hold  (freeze),
        .busy  (md_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RUN;
        end else begin
            state <= next_state;
        end
    end

    // MEM_WAIT with memory ready behaves exactly like RUN, so the stall is
    // released in the same cycle the access completes.
    always_comb begin
        next_state = state;
        stallF     = 1'b0;
        stallD     = 1'b0;
        isLWHazard = 1'b0;
        freeze     = 1'b0;
        drain_load = 1'b0;
        drain_dec  = 1'b0;
        case (state)
            S_RUN, S_MEM_WAIT: begin
                if (!memReadyM) begin
                    freeze     = 1'b1;
                    stallF     = 1'b1;
                    stallD     = 1'b1;
                    next_state = S_MEM_WAIT;
                end else begin
                    next_state = S_RUN;
                    if (any_haz) begin
                        stallF     = 1'b1;
                        stallD     = 1'b1;
                        isLWHazard = 1'b1;
                    end else if (StopD) begin
                        drain_load = 1'b1;
                        next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                stallF = 1'b1;
                stallD = 1'b1;
                if (!memReadyM) begin
                    freeze = 1'b1;
                end else begin
                    isLWHazard = 1'b1;
                    drain_dec  = 1'b1;
                    if (drain_cnt <= DW'(1)) begin
                        next_state = S_HALT;
                    end
                end
            end
            S_HALT: begin
                stallF     = 1'b1;
                stallD     = 1'b1;
                isLWHazard = 1'b1;
            end
            default: next_state = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
        end else if (drain_load) begin
            drain_cnt <= DW'(DRAIN);
        end else if (drain_dec) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            halted <= (next_state == S_HALT);
            if (stallD && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
